// File: rtl/muldiv_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl_pkg
// Shared definitions for the HI/LO arithmetic sequencing controller:
//   - EX operation encodings for mult/multu/div/divu
//   - controller state encoding
//   - the codebase-wide Stop/NoStop stall levels and ZeroWord constant
// -----------------------------------------------------------------------------
package muldiv_ctrl_pkg;

    // HI/LO operation select as presented by EX on req_op.
    // Bit 0 set means the unsigned variant.
    localparam logic [1:0] MULDIV_MULT  = 2'd0;
    localparam logic [1:0] MULDIV_MULTU = 2'd1;
    localparam logic [1:0] MULDIV_DIV   = 2'd2;
    localparam logic [1:0] MULDIV_DIVU  = 2'd3;

    // Stall request levels and the all-zero data word.
    localparam logic        Stop     = 1'b1;
    localparam logic        NoStop   = 1'b0;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_DIV_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_watchdog.sv
// -----------------------------------------------------------------------------
// muldiv_watchdog
// Busy-cycle counter guarding a running HI/LO unit.
//   clk, rst : clock, synchronous active-high reset
//   en       : a unit is running this cycle (counter advances)
//   clr      : controller leaves the running state (counter returns to 0)
//   expire   : running cycle number TIMEOUT-1 reached (cycles numbered from 0)
// Parameters: TIMEOUT (max running cycles), CNT_W (counter width).
// -----------------------------------------------------------------------------
module muldiv_watchdog #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The controller always leaves the running state on expiry, so the
    // counter never wraps.
    assign expire = en && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// Sequences one mult/multu/div/divu from EX onto the iterative multiplier or
// divider, stalls EX until the 64-bit result exists, and holds that result
// until the pipeline advances past EX. Handles flush/bubble annul and a hung
// unit (watchdog).
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   flush                      kill the instruction in EX
//   stall_down                 stage after EX is stalled this cycle
//   req_valid, req_op          HI/LO instruction in EX and its operation
//   src_a, src_b               rs / rt operands
//   mul_start/div_start        level start to the selected unit
//   mul_signed/div_signed      signed operation select
//   mul_opa/opb, div_opa/opb   latched operands
//   mul_annul/div_annul        one-cycle abort pulse
//   mul_ready/div_ready        one-cycle result-valid pulse from unit
//   mul_result/div_result      unit result (div: {remainder, quotient})
//   stallreq                   EX stall request
//   res_valid, hi, lo          result for the current instruction
//   err_timeout                one-cycle pulse on watchdog expiry
//
// Build option: define MULDIV_DIV0_FAST_EN to complete div/divu by zero in
// the controller (hi=src_a, lo=all ones) without starting the divider.
// -----------------------------------------------------------------------------
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_down,
    input  logic        req_valid,
    input  logic [1:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        mul_start,
    output logic        div_start,
    output logic        mul_signed,
    output logic        div_signed,
    output logic [31:0] mul_opa,
    output logic [31:0] mul_opb,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        mul_annul,
    output logic        div_annul,
    input  logic        mul_ready,
    input  logic        div_ready,
    input  logic [63:0] mul_result,
    input  logic [63:0] div_result,
    output logic        stallreq,
    output logic        res_valid,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err_timeout
);

    state_e      state_q, state_d;
    logic [31:0] mul_opa_q, mul_opa_d;
    logic [31:0] mul_opb_q, mul_opb_d;
    logic [31:0] div_opa_q, div_opa_d;
    logic [31:0] div_opb_q, div_opb_d;
    logic        mul_signed_q, mul_signed_d;
    logic        div_signed_q, div_signed_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic kill;
    logic div0_fast;
    logic wd_run;
    logic wd_clr;
    logic wd_expire;

    // A bubble arriving while a unit is running means the instruction left
    // EX without completing; it is handled exactly like a flush.
    assign kill = flush || !req_valid;

`ifdef MULDIV_DIV0_FAST_EN
    assign div0_fast = (src_b == ZeroWord);
`else
    assign div0_fast = 1'b0;
`endif

    assign wd_run = (state_q == ST_MUL_RUN) || (state_q == ST_DIV_RUN);
    assign wd_clr = (state_d != ST_MUL_RUN) && (state_d != ST_DIV_RUN);

    muldiv_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_run),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        mul_opa_d    = mul_opa_q;
        mul_opb_d    = mul_opb_q;
        div_opa_d    = div_opa_q;
        div_opb_d    = div_opb_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        mul_annul    = 1'b0;
        div_annul    = 1'b0;
        err_timeout  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && !flush) begin
                    case (req_op)
                        MULDIV_MULT, MULDIV_MULTU: begin
                            mul_opa_d    = src_a;
                            mul_opb_d    = src_b;
                            mul_signed_d = ~req_op[0];
                            state_d      = ST_MUL_RUN;
                        end
                        MULDIV_DIV, MULDIV_DIVU: begin
                            if (div0_fast) begin
                                hi_d    = src_a;
                                lo_d    = 32'hFFFF_FFFF;
                                state_d = ST_DONE;
                            end else begin
                                div_opa_d    = src_a;
                                div_opb_d    = src_b;
                                div_signed_d = ~req_op[0];
                                state_d      = ST_DIV_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            // Kill outranks a same-cycle ready; ready outranks expiry.
            ST_MUL_RUN: begin
                if (kill) begin
                    mul_annul = 1'b1;
                    state_d   = ST_IDLE;
                end else if (mul_ready) begin
                    {hi_d, lo_d} = mul_result;
                    state_d      = ST_DONE;
                end else if (wd_expire) begin
                    hi_d        = ZeroWord;
                    lo_d        = ZeroWord;
                    mul_annul   = 1'b1;
                    err_timeout = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            ST_DIV_RUN: begin
                if (kill) begin
                    div_annul = 1'b1;
                    state_d   = ST_IDLE;
                end else if (div_ready) begin
                    {hi_d, lo_d} = div_result;
                    state_d      = ST_DONE;
                end else if (wd_expire) begin
                    hi_d        = ZeroWord;
                    lo_d        = ZeroWord;
                    div_annul   = 1'b1;
                    err_timeout = 1'b1;
                    state_d     = ST_DONE;
                end
            end

            // Result is held until EX is actually taken; no relaunch while
            // the instruction still sits in EX.
            ST_DONE: begin
                if (flush || !stall_down) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // The units share rst, so reset never needs an explicit abort.
        if (rst) begin
            mul_annul   = 1'b0;
            div_annul   = 1'b0;
            err_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mul_opa_q    <= ZeroWord;
            mul_opb_q    <= ZeroWord;
            div_opa_q    <= ZeroWord;
            div_opb_q    <= ZeroWord;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            hi_q         <= ZeroWord;
            lo_q         <= ZeroWord;
        end else begin
            state_q      <= state_d;
            mul_opa_q    <= mul_opa_d;
            mul_opb_q    <= mul_opb_d;
            div_opa_q    <= div_opa_d;
            div_opb_q    <= div_opb_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
        end
    end

    assign stallreq   = (req_valid && !flush && (state_q != ST_DONE)) ? Stop : NoStop;
    assign res_valid  = (state_q == ST_DONE);
    assign mul_start  = (state_q == ST_MUL_RUN);
    assign div_start  = (state_q == ST_DIV_RUN);
    assign mul_signed = mul_signed_q;
    assign div_signed = div_signed_q;
    assign mul_opa    = mul_opa_q;
    assign mul_opb    = mul_opb_q;
    assign div_opa    = div_opa_q;
    assign div_opb    = div_opb_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// tb_muldiv_ctrl
// Directed bench for muldiv_ctrl with behavioural multiplier/divider models.
// Expected {hi,lo} values are queued when an instruction is issued and
// checked when the DUT presents a result that the pipeline takes.
// -----------------------------------------------------------------------------
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        stall_down;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mul_start, div_start;
    logic        mul_signed, div_signed;
    logic [31:0] mul_opa, mul_opb, div_opa, div_opb;
    logic        mul_annul, div_annul;
    logic        mul_ready = 1'b0;
    logic        div_ready = 1'b0;
    logic [63:0] mul_result = 64'h0;
    logic [63:0] div_result = 64'h0;
    logic        stallreq;
    logic        res_valid;
    logic [31:0] hi, lo;
    logic        err_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    // unit model controls
    int          mul_lat = 8;
    int          div_lat = 5;
    bit          mul_hang = 1'b0;
    bit          stray_div = 1'b0;
    logic [63:0] mul_ret = 64'h0;
    logic [63:0] div_ret = 64'h0;
    int          mc = 0;
    int          dc = 0;
    localparam logic [63:0] JUNK = 64'hA5A5_0000_5A5A_FFFF;

    muldiv_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .stall_down  (stall_down),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .src_a       (src_a),
        .src_b       (src_b),
        .mul_start   (mul_start),
        .div_start   (div_start),
        .mul_signed  (mul_signed),
        .div_signed  (div_signed),
        .mul_opa     (mul_opa),
        .mul_opb     (mul_opb),
        .div_opa     (div_opa),
        .div_opb     (div_opb),
        .mul_annul   (mul_annul),
        .div_annul   (div_annul),
        .mul_ready   (mul_ready),
        .div_ready   (div_ready),
        .mul_result  (mul_result),
        .div_result  (div_result),
        .stallreq    (stallreq),
        .res_valid   (res_valid),
        .hi          (hi),
        .lo          (lo),
        .err_timeout (err_timeout)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mulref(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] divuref(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Advance until stallreq drops (result presented); bounded.
    task automatic wait_done(input string tag, output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            smp();
            if (!stallreq) return;
            n++;
            cyc();
        end
        chk(tag, {63'b0, stallreq}, 64'd0);
    endtask

    // Behavioural units: count start cycles, pulse ready after the latency.
    initial forever begin
        @(posedge clk);
        #1;
        if (mul_start && !mul_hang) begin
            mc++;
            mul_ready = (mc == mul_lat);
        end else begin
            mc = 0;
            mul_ready = 1'b0;
        end
        if (div_start) begin
            dc++;
            div_ready = (dc == div_lat);
        end else begin
            dc = 0;
            div_ready = 1'b0;
        end
        if (stray_div && mul_start && mc == 2) div_ready = 1'b1;
        mul_result = mul_ready ? mul_ret : JUNK;
        div_result = div_ready ? div_ret : JUNK;
    end

    // Scoreboard: compare when the pipeline takes a valid result.
    always @(negedge clk) begin
        if (rst === 1'b0 && res_valid === 1'b1 && stall_down === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res_valid", {63'b0, res_valid}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("result_hilo", {hi, lo}, mon_exp);
            end
        end
    end

    initial begin
        int n;
        int busy, err_idx, err_cnt, annul_cnt, rv_cnt, start_cnt;
        logic ann;
        bit hit;

        rst = 1'b1; flush = 1'b0; stall_down = 1'b0; req_valid = 1'b0;
        req_op = 2'd0; src_a = 32'h0; src_b = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        smp();
        chk("rst_stallreq",  {63'b0, stallreq},   64'd0);
        chk("rst_res_valid", {63'b0, res_valid},  64'd0);
        chk("rst_hilo",      {hi, lo},            64'd0);
        chk("rst_starts",    {62'b0, mul_start, div_start}, 64'd0);
        chk("rst_err",       {63'b0, err_timeout}, 64'd0);
        chk("rst_annul",     {62'b0, mul_annul, div_annul}, 64'd0);
        chk("rst_ops",       {mul_opa, div_opb},  64'd0);

        // mult -2 * 3, ready on 8th busy cycle, stray div_ready ignored
        cyc();
        mul_lat = 8; stray_div = 1'b1;
        req_op = 2'd0; src_a = 32'hFFFF_FFFE; src_b = 32'd3; req_valid = 1'b1;
        mul_ret = mulref(src_a, src_b, 1'b1);
        exp_q.push_back(mul_ret);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            smp();
            if (!stallreq) break;
            n++;
            if (i == 3) begin
                chk("mult_signed", {63'b0, mul_signed}, 64'd1);
                chk("mult_ops", {mul_opa, mul_opb}, {32'hFFFF_FFFE, 32'd3});
                chk("mult_no_div_start", {63'b0, div_start}, 64'd0);
            end
            cyc();
        end
        chk("mult_stall_cycles", 64'(n), 64'd9);
        chk("mult_res_valid", {63'b0, res_valid}, 64'd1);
        cyc(); req_valid = 1'b0; stray_div = 1'b0;
        smp();
        chk("mult_res_valid_1cyc", {63'b0, res_valid}, 64'd0);

        // divu 100 / 7 with downstream stall for 5 cycles
        cyc();
        div_lat = 5; stall_down = 1'b1;
        req_op = 2'd3; src_a = 32'd100; src_b = 32'd7; req_valid = 1'b1;
        div_ret = divuref(src_a, src_b);
        exp_q.push_back(div_ret);
        wait_done("divu_done_bound", n);
        for (int k = 0; k < 5; k++) begin
            chk("divu_hold_valid", {63'b0, res_valid}, 64'd1);
            chk("divu_hold_hilo", {hi, lo}, 64'h0000_0002_0000_000E);
            chk("divu_no_relaunch", {63'b0, div_start}, 64'd0);
            cyc();
            if (k == 4) stall_down = 1'b0;
            smp();
        end
        cyc(); req_valid = 1'b0;
        smp();
        chk("divu_idle_valid", {63'b0, res_valid}, 64'd0);
        chk("divu_idle_start", {63'b0, div_start}, 64'd0);

        // multu with a hung multiplier: watchdog
        cyc();
        mul_hang = 1'b1;
        req_op = 2'd1; src_a = 32'd7; src_b = 32'd9; req_valid = 1'b1;
        exp_q.push_back(64'd0);
        busy = 0; err_idx = -1; err_cnt = 0; ann = 1'b0;
        for (int i = 0; i < 100; i++) begin
            smp();
            if (err_timeout) begin
                err_cnt++;
                err_idx = busy;
                ann = mul_annul;
            end
            if (mul_start) busy++;
            if (i > 0 && !stallreq) break;
            cyc();
        end
        chk("wd_err_cycle", 64'(err_idx), 64'd63);
        chk("wd_err_once", 64'(err_cnt), 64'd1);
        chk("wd_annul", {63'b0, ann}, 64'd1);
        chk("wd_busy_cycles", 64'(busy), 64'd64);
        chk("wd_stall_drop", {63'b0, stallreq}, 64'd0);
        chk("wd_unsigned", {63'b0, mul_signed}, 64'd0);
        cyc(); req_valid = 1'b0; mul_hang = 1'b0;
        smp();

        // div with flush on the same cycle as div_ready
        cyc();
        div_lat = 4;
        req_op = 2'd2; src_a = 32'd50; src_b = 32'd5; req_valid = 1'b1;
        div_ret = 64'h0000_0000_0000_000A;
        hit = 1'b0; annul_cnt = 0; rv_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            smp();
            if (div_annul) annul_cnt++;
            cyc();
            if (div_ready) begin
                flush = 1'b1;
                hit = 1'b1;
                break;
            end
        end
        chk("flush_ready_seen", {63'b0, hit}, 64'd1);
        smp();
        chk("flush_annul", {63'b0, div_annul}, 64'd1);
        chk("flush_stallreq", {63'b0, stallreq}, 64'd0);
        if (div_annul) annul_cnt++;
        cyc(); flush = 1'b0; req_valid = 1'b0;
        smp();
        chk("flush_idle_start", {63'b0, div_start}, 64'd0);
        chk("flush_idle_valid", {63'b0, res_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            if (div_annul) annul_cnt++;
            if (res_valid) rv_cnt++;
            cyc();
            smp();
        end
        chk("flush_annul_once", 64'(annul_cnt), 64'd1);
        chk("flush_no_result", 64'(rv_cnt), 64'd0);

        // back-to-back mult 3*4 then 5*6; first result held 2 extra cycles
        cyc();
        mul_lat = 3; stall_down = 1'b1;
        req_op = 2'd0; src_a = 32'd3; src_b = 32'd4; req_valid = 1'b1;
        mul_ret = mulref(src_a, src_b, 1'b1);
        exp_q.push_back(mul_ret);
        wait_done("b2b_first_bound", n);
        chk("b2b_hold1", {hi, lo}, 64'd12);
        cyc();
        smp();
        chk("b2b_hold2", {hi, lo}, 64'd12);
        chk("b2b_hold2_valid", {63'b0, res_valid}, 64'd1);
        cyc(); stall_down = 1'b0;
        smp();
        cyc();
        src_a = 32'd5; src_b = 32'd6;
        mul_ret = mulref(src_a, src_b, 1'b1);
        exp_q.push_back(mul_ret);
        smp();
        chk("b2b_idle_stall", {63'b0, stallreq}, 64'd1);
        chk("b2b_idle_nostart", {63'b0, mul_start}, 64'd0);
        cyc();
        smp();
        chk("b2b_second_start", {63'b0, mul_start}, 64'd1);
        chk("b2b_second_ops", {mul_opa, mul_opb}, {32'd5, 32'd6});
        wait_done("b2b_second_bound", n);
        cyc(); req_valid = 1'b0;
        smp();

        // bubble (req_valid drop) while dividing acts as flush
        cyc();
        div_lat = 20;
        req_op = 2'd3; src_a = 32'd9; src_b = 32'd2; req_valid = 1'b1;
        smp(); cyc(); smp();
        chk("bubble_running", {63'b0, div_start}, 64'd1);
        cyc(); req_valid = 1'b0;
        smp();
        chk("bubble_annul", {63'b0, div_annul}, 64'd1);
        cyc();
        smp();
        chk("bubble_idle", {61'b0, div_start, res_valid, div_annul}, 64'd0);

        // divide by zero
        cyc();
        div_lat = 3;
        req_op = 2'd2; src_a = 32'h0000_1234; src_b = 32'd0; req_valid = 1'b1;
        div_ret = 64'hCAFE_0000_0000_BEEF;
`ifdef MULDIV_DIV0_FAST_EN
        exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
        start_cnt = 0;
        smp();
        chk("div0_accept_stall", {63'b0, stallreq}, 64'd1);
        cyc();
        smp();
        chk("div0_done_valid", {63'b0, res_valid}, 64'd1);
        chk("div0_done_stall", {63'b0, stallreq}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            if (div_start) start_cnt++;
            cyc();
            if (i == 0) req_valid = 1'b0;
            smp();
        end
        chk("div0_never_started", 64'(start_cnt), 64'd0);
`else
        exp_q.push_back(div_ret);
        smp(); cyc(); smp();
        chk("div0_start", {63'b0, div_start}, 64'd1);
        chk("div0_ops", {div_opa, div_opb}, {32'h0000_1234, 32'd0});
        wait_done("div0_done_bound", n);
        chk("div0_done_valid", {63'b0, res_valid}, 64'd1);
        cyc(); req_valid = 1'b0;
        smp();
`endif

        // reset in the middle of a multiply
        cyc();
        mul_lat = 20;
        req_op = 2'd0; src_a = 32'd11; src_b = 32'd13; req_valid = 1'b1;
        smp(); cyc(); smp(); cyc();
        rst = 1'b1; req_valid = 1'b0;
        smp();
        chk("rst_mid_no_annul", {62'b0, mul_annul, div_annul}, 64'd0);
        cyc(); rst = 1'b0;
        smp();
        chk("rst_mid_idle", {61'b0, mul_start, div_start, res_valid}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
        chk("rst_mid_ops", {mul_opa, mul_opb}, 64'd0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequencing controller between the EX stage and the two multi-cycle HI/LO arithmetic units: the iterative multiplier and the iterative divider.
- Accepts a mult/multu/div/divu request from EX, launches exactly one operation on the correct unit, and raises the EX stall request until the result exists.
- Holds the 64-bit result stable until the pipeline actually advances past EX, so a downstream stall never causes a restart or a lost result.
- Handles flush (annul) and detects a hung unit.

Parameters:
- TIMEOUT, 64, max cycles in a RUN state before forced completion with error.
- CNT_W, 7, width of busy cycle counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill instruction in EX.
- stall_down  in  1  stage after EX is stalled (EX output not taken this cycle).
- req_valid  in  1  a HI/LO arithmetic instruction occupies EX; held high for its whole EX residency.
- req_op  in  2  0=mult, 1=multu, 2=div, 3=divu.
- src_a  in  32  rs operand.
- src_b  in  32  rt operand.
- mul_start / div_start  out  1  level start to unit.
- mul_signed / div_signed  out  1  signed operation select.
- mul_opa, mul_opb, div_opa, div_opb  out  32 each  latched operands.
- mul_annul / div_annul  out  1  one-cycle abort pulse.
- mul_ready / div_ready  in  1  one-cycle result-valid pulse from unit.
- mul_result / div_result  in  64  unit result; div result is {remainder, quotient}.
- stallreq  out  1  stall request for EX.
- res_valid  out  1  hi/lo valid for current instruction.
- hi, lo  out  32 each  result halves.
- err_timeout  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset: state IDLE; all outputs 0; operand, result and counter registers 0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE.
- stallreq = req_valid & (state != DONE). It is combinational, so it asserts in the same cycle the request first appears. stallreq is 0 whenever flush=1.
- IDLE, req_valid=1, flush=0:
  - Latch src_a/src_b into the selected unit's operand registers.
  - Latch signed = ~req_op[0].
  - Next state: MUL_RUN for ops 0/1, DIV_RUN for ops 2/3.
- MUL_RUN / DIV_RUN:
  - The matching *_start is 1 for every cycle in the state; the other unit's start is 0.
  - Operands stay stable.
  - busy counter increments each cycle.
- ready pulse in RUN: latch {hi,lo} = result; clear counter; go to DONE. The ready pulse of the non-selected unit is ignored.
- Watchdog: when the counter reaches TIMEOUT-1 with no ready:
  - hi=lo=0, err_timeout=1 for one cycle;
  - the selected unit's annul pulses once;
  - go to DONE.
- DONE:
  - res_valid=1; hi/lo held; start=0.
  - stall_down=0: go to IDLE; res_valid drops next cycle.
  - stall_down=1: stay in DONE; no restart even though req_valid remains 1.
- flush in any state (highest priority, including on the same cycle as ready):
  - go to IDLE; discard any result;
  - if in a RUN state, pulse the active unit's annul for one cycle;
  - res_valid=0 next cycle.
- req_valid falling while in RUN (bubble injected without flush): treat as flush.
- Back-to-back requests: after DONE→IDLE, a new req_valid is accepted the following cycle with no dead cycle beyond that.
- Reset mid-operation: immediate return to IDLE; no annul is issued, because the units share rst.

Optional Feature:
- Macro: MULDIV_DIV0_FAST_EN.
- Defined:
  - div/divu with src_b==0 in IDLE goes directly to DONE next cycle.
  - hi=src_a, lo=32'hFFFF_FFFF; the divider is never started.
  - stallreq is 1 for exactly the accept cycle.
- Undefined: divide-by-zero is dispatched to the divider like any other division, and its result is passed through unmodified.

Decomposition:
- Shared defines header: op encodings (MULDIV_MULT/MULTU/DIV/DIVU) and state encodings.
- Reuse existing Stop/NoStop and ZeroWord constants.
- One sub-module: muldiv_watchdog (counter, clear/enable, expiry pulse).

Test Plan:
- mult, src_a=32'hFFFF_FFFE (-2), src_b=3, mul_ready after 8 cycles:
  - stallreq high for 9 cycles, mul_signed=1;
  - hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA; res_valid for 1 cycle.
- divu, src_a=100, src_b=7, stall_down=1 for 5 cycles after ready:
  - DONE held with hi=2, lo=14;
  - div_start stays 0, no second launch.
- div running, flush on the same cycle as div_ready:
  - div_annul pulses once; res_valid never asserts; state IDLE next cycle.
- multu with no ready ever, TIMEOUT=64:
  - err_timeout pulses at busy cycle 63; hi=lo=0; stallreq drops.
- Two back-to-back mult instructions (3×4 then 5×6):
  - lo=12 then lo=30; each result held until the pipeline advances; no operand mixing.
- div src_b=0:
  - with MULDIV_DIV0_FAST_EN, hi=src_a, lo=32'hFFFF_FFFF after 1 cycle and div_start never asserts;
  - without it, div_start asserts normally.
